// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data_mem arbiter.
package mem_arb_pkg;

  localparam int unsigned DefAddrW = 11;
  localparam int unsigned DefDataW = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDATA
  } arb_state_t;

  // Sized to the default widths; the top narrows fields back to its own parameters.
  typedef struct packed {
    logic                we;
    logic [DefAddrW-1:0] addr;
    logic [DefDataW-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter with a round-robin pointer and an optional fixed-priority override.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  input  logic       fixed_pri_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;  // 0: m0 favoured on a tie, 1: m1 favoured

  // Grant: a lone requester always wins; ties go to the pointer (or m0 when fixed).
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (fixed_pri_i || !ptr_q) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // After any grant, favour the side that did not win.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && (gnt_o != 2'b00)) ptr_d = gnt_o[0];
  end

  // Pointer register, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Serialises cpu (m0) and debug/loader (m1) accesses onto the single-port data_mem.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q
);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;  // 0: m0 owns the access in flight
  logic              is_wr_q, is_wr_d;
  logic              mem_wren_q, mem_wren_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic       win;
  logic [1:0] req_win;
  logic [1:0] gnt;
  logic       gnt_any;
  mem_cmd_t   cmd_sel;

  // A new command may be accepted whenever the memory port is free next cycle.
  always_comb begin
    win     = (state_q == IDLE) || (state_q == RDATA) || ((state_q == ISSUE) && is_wr_q);
    req_win = (win && rst_n) ? {m1_req, m0_req} : 2'b00;
  end

  rr_arbiter2 u_rr (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req_win),
    .advance_i   (win && rst_n),
    .fixed_pri_i (FIXED_PRI != 0),
    .gnt_o       (gnt)
  );

  // Select the winning requester's command as sampled in the grant cycle.
  always_comb begin
    gnt_any = gnt[0] | gnt[1];
    if (gnt[1]) begin
      cmd_sel.we    = m1_we;
      cmd_sel.addr  = DefAddrW'(m1_addr);
      cmd_sel.wdata = DefDataW'(m1_wdata);
    end else begin
      cmd_sel.we    = m0_we;
      cmd_sel.addr  = DefAddrW'(m0_addr);
      cmd_sel.wdata = DefDataW'(m0_wdata);
    end
  end

  // Next-state, command latching and read-return steering.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    is_wr_d    = is_wr_q;
    mem_wren_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    unique case (state_q)
      IDLE, RDATA: state_d = gnt_any ? ISSUE : IDLE;
      ISSUE:       state_d = is_wr_q ? (gnt_any ? ISSUE : IDLE) : RDATA;
      default:     state_d = IDLE;
    endcase
    if (gnt_any) begin
      owner_d    = gnt[1];
      is_wr_d    = cmd_sel.we;
      mem_wren_d = cmd_sel.we;
      mem_addr_d = ADDR_W'(cmd_sel.addr);
      mem_data_d = DATA_W'(cmd_sel.wdata);
    end
    m0_rvalid = (state_q == RDATA) && !owner_q;
    m1_rvalid = (state_q == RDATA) && owner_q;
    rdata0_d  = m0_rvalid ? mem_q : rdata0_q;
    rdata1_d  = m1_rvalid ? mem_q : rdata1_q;
  end

  // State and command registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      is_wr_q    <= 1'b0;
      mem_wren_q <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      is_wr_q    <= is_wr_d;
      mem_wren_q <= mem_wren_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // Read data is forwarded from mem_q in the rvalid cycle and held afterwards.
  always_comb begin
    m0_gnt   = gnt[0];
    m1_gnt   = gnt[1];
    m0_rdata = rdata0_d;
    m1_rdata = rdata1_d;
    mem_wren = mem_wren_q;
    mem_addr = mem_addr_q;
    mem_data = mem_data_q;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a read-data scoreboard per requester.
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Round-robin instance
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [10:0] m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_wren;
  logic [31:0] m0_rdata, m1_rdata, mem_data, mem_q;
  logic [10:0] mem_addr;

  // Fixed-priority instance
  logic        f_m0_req = 0, f_m1_req = 0;
  logic [10:0] f_m0_addr = 0, f_m1_addr = 0;
  logic        f_m0_gnt, f_m0_rvalid, f_m1_gnt, f_m1_rvalid, f_mem_wren;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_mem_data, f_mem_q;
  logic [10:0] f_mem_addr;

  data_mem_arbiter #(.ADDR_W(11), .DATA_W(32), .FIXED_PRI(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_data(mem_data), .mem_q(mem_q)
  );

  data_mem_arbiter #(.ADDR_W(11), .DATA_W(32), .FIXED_PRI(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req(f_m0_req), .m0_we(1'b0), .m0_addr(f_m0_addr), .m0_wdata(32'h0),
    .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata),
    .m1_req(f_m1_req), .m1_we(1'b0), .m1_addr(f_m1_addr), .m1_wdata(32'h0),
    .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata),
    .mem_wren(f_mem_wren), .mem_addr(f_mem_addr), .mem_data(f_mem_data), .mem_q(f_mem_q)
  );

  // Synchronous-read memory models and the bench's own shadow copy
  logic [31:0] mem_a [0:2047];
  logic [31:0] mem_f [0:2047];
  logic [31:0] shadow [0:2047];

  always @(posedge clk) begin
    if (mem_wren) mem_a[mem_addr] <= mem_data;
    mem_q <= mem_a[mem_addr];
  end

  always @(posedge clk) begin
    if (f_mem_wren) mem_f[f_mem_addr] <= f_mem_data;
    f_mem_q <= mem_f[f_mem_addr];
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Read-return scoreboard and mutual-exclusion check
  always @(negedge clk) begin
    if (rst_n) begin
      check("both_gnt", 32'(m0_gnt & m1_gnt), 32'h0);
      if (m0_rvalid) begin
        if (q0.size() == 0) check("m0_spurious_rvalid", 32'(m0_rvalid), 32'h0);
        else check("m0_rdata", m0_rdata, q0.pop_front());
      end
      if (m1_rvalid) begin
        if (q1.size() == 0) check("m1_spurious_rvalid", 32'(m1_rvalid), 32'h0);
        else check("m1_rdata", m1_rdata, q1.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int side, input logic r, input logic we, input logic [10:0] a,
                         input logic [31:0] d);
    if (side == 0) begin
      m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d;
    end
  endtask

  // Request until granted (bounded), update the model, then release the request.
  task automatic access(input int side, input logic we, input logic [10:0] a,
                        input logic [31:0] d, output int lat);
    logic seen;
    seen = 1'b0;
    lat  = -1;
    set_req(side, 1'b1, we, a, d);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((side == 0 && m0_gnt) || (side == 1 && m1_gnt)) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
      cyc();
    end
    check("gnt_seen", 32'(seen), 32'h1);
    if (seen) begin
      if (we) shadow[a] = d;
      else if (side == 0) q0.push_back(shadow[a]);
      else q1.push_back(shadow[a]);
    end
    cyc();
    set_req(side, 1'b0, 1'b0, 11'h0, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (q0.size() == 0 && q1.size() == 0) break;
    end
    check("drain", 32'(q0.size() + q1.size()), 32'h0);
  endtask

  task automatic reset_check(input string tag);
    rst_n = 1'b0;
    cyc();
    @(negedge clk);
    check({tag, "_wren"}, 32'(mem_wren), 32'h0);
    check({tag, "_addr"}, 32'(mem_addr), 32'h0);
    check({tag, "_data"}, mem_data, 32'h0);
    check({tag, "_rvalid"}, 32'({m1_rvalid, m0_rvalid}), 32'h0);
    check({tag, "_m0_rdata"}, m0_rdata, 32'h0);
    check({tag, "_m1_rdata"}, m1_rdata, 32'h0);
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    int  k;
    int  last;
    int  cnt;
    logic seen;

    for (int i = 0; i < 2048; i++) begin
      shadow[i] = 32'hA500_0000 ^ 32'(i);
      mem_a[i]  = shadow[i];
      mem_f[i]  = shadow[i];
    end
    shadow[5] = 32'hDEADBEEF;
    mem_a[5]  = 32'hDEADBEEF;
    mem_f[5]  = 32'hDEADBEEF;

    cyc();
    reset_check("rst0");

    // Single read of 0x005 by m0
    access(0, 1'b0, 11'h005, 32'h0, lat);
    check("t1_lat", 32'(lat), 32'h0);
    @(negedge clk);
    check("t1_c1_addr", 32'(mem_addr), 32'h005);
    check("t1_c1_wren", 32'(mem_wren), 32'h0);
    check("t1_c1_rvalid", 32'(m0_rvalid), 32'h0);
    cyc();
    @(negedge clk);
    check("t1_c2_rvalid", 32'(m0_rvalid), 32'h1);
    cyc();
    @(negedge clk);
    check("t1_c3_rvalid", 32'(m0_rvalid), 32'h0);
    check("t1_c3_hold", m0_rdata, 32'hDEADBEEF);
    cyc();

    // m1 write then m0 read of the same word
    access(1, 1'b1, 11'h010, 32'h12345678, lat);
    @(negedge clk);
    check("t2_wren", 32'(mem_wren), 32'h1);
    check("t2_addr", 32'(mem_addr), 32'h010);
    check("t2_data", mem_data, 32'h12345678);
    cyc();
    @(negedge clk);
    check("t2_wren_off", 32'(mem_wren), 32'h0);
    cyc();
    access(0, 1'b0, 11'h010, 32'h0, lat);
    drain();
    check("t2_m0_rdata", m0_rdata, 32'h12345678);

    reset_check("rst1");

    // Round-robin tie: both hold reads for six grants
    set_req(0, 1'b1, 1'b0, 11'h020, 32'h0);
    set_req(1, 1'b1, 1'b0, 11'h021, 32'h0);
    k = 0;
    last = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m0_gnt || m1_gnt) begin
        if (m0_gnt) q0.push_back(shadow[11'h020]);
        if (m1_gnt) q1.push_back(shadow[11'h021]);
        check("rr_order", 32'(m1_gnt), 32'(k % 2));
        if (k > 0) check("rr_spacing", 32'(i - last), 32'h2);
        last = i;
        k++;
      end
      cyc();
      if (k == 6) break;
    end
    check("rr_grants", 32'(k), 32'h6);
    set_req(0, 1'b0, 1'b0, 11'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 11'h0, 32'h0);
    drain();

    // Back-to-back write burst 0x000..0x003
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b1, 1'b1, 11'(i), 32'hB000_0000 + 32'(i));
      @(negedge clk);
      check("wb_gnt", 32'(m0_gnt), 32'h1);
      if (i > 0) begin
        check("wb_wren", 32'(mem_wren), 32'h1);
        check("wb_addr", 32'(mem_addr), 32'(i - 1));
      end
      shadow[i] = 32'hB000_0000 + 32'(i);
      cyc();
    end
    set_req(0, 1'b0, 1'b0, 11'h0, 32'h0);
    @(negedge clk);
    check("wb_wren_last", 32'(mem_wren), 32'h1);
    check("wb_addr_last", 32'(mem_addr), 32'h3);
    cyc();
    @(negedge clk);
    check("wb_wren_end", 32'(mem_wren), 32'h0);
    cyc();
    access(1, 1'b0, 11'h002, 32'h0, lat);
    drain();

    // Reset in the cycle after a read grant
    set_req(0, 1'b1, 1'b0, 11'h005, 32'h0);
    @(negedge clk);
    check("rm_gnt", 32'(m0_gnt), 32'h1);
    cyc();
    set_req(0, 1'b0, 1'b0, 11'h0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rm_issue_addr", 32'(mem_addr), 32'h005);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("rm_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);
    check("rm_addr", 32'(mem_addr), 32'h0);
    check("rm_wren", 32'(mem_wren), 32'h0);
    check("rm_m0_rdata", m0_rdata, 32'h0);
    check("rm_m1_rdata", m1_rdata, 32'h0);
    cyc();
    access(1, 1'b0, 11'h010, 32'h0, lat);
    check("rm_next_lat", 32'(lat), 32'h0);
    drain();

    // Fixed priority: m1 starves while m0 requests continuously
    f_m0_addr = 11'h020;
    f_m1_addr = 11'h021;
    f_m0_req  = 1'b1;
    f_m1_req  = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("fp_m1_starve", 32'(f_m1_gnt), 32'h0);
      if (f_m0_gnt) cnt++;
      cyc();
    end
    check("fp_m0_grants", 32'(cnt), 32'h6);
    f_m0_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (f_m1_gnt) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
    check("fp_m1_after_drop", 32'(seen), 32'h1);
    cyc();
    f_m1_req = 1'b0;
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
